// File: rtl/score_display_n.sv
// Game score counter with BCD ripple increment and a multiplexed 7-segment display.
// Define SCORE_HISCORE_EN to add the high-score latch and the show_hi display source.
module score_display_n #(
  parameter int DIGITS    = 4,
  parameter int TICK_SLOW = 2000000,
  parameter int TICK_FAST = 1000000,
  parameter int SCAN_DIV  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  run,
  input  logic                  clear,
  input  logic                  speed,
  input  logic                  show_hi,
  output logic [DIGITS-1:0]     seg_sel,
  output logic [7:0]            SM,
  output logic [4*DIGITS-1:0]   score_bcd,
  output logic [4*DIGITS-1:0]   hiscore_bcd,
  output logic                  overflow
);

  localparam int TMAX = (TICK_SLOW > TICK_FAST) ? TICK_SLOW : TICK_FAST;
  localparam int CW   = $clog2(TMAX);
  localparam int SW   = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW   = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  logic [CW-1:0]       tick_cnt;
  logic [CW-1:0]       tick_last;
  logic                tick;
  logic [4*DIGITS-1:0] score_inc;
  logic                carry;
  logic [4*DIGITS-1:0] disp;
  logic [SW-1:0]       scan_cnt;
  logic                scan_wrap;
  logic [IW-1:0]       idx;
  logic [IW-1:0]       idx_nxt;
  logic [DIGITS-1:0]   sel_nxt;
  logic [3:0]          dig;
  logic                blank;
  logic                nz;

  // ">=" rather than "==" so a switch to the shorter period never skips a tick
  assign tick_last = speed ? CW'(TICK_FAST - 1) : CW'(TICK_SLOW - 1);
  assign tick      = (tick_cnt >= tick_last);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) tick_cnt <= '0;
    else        tick_cnt <= tick ? '0 : tick_cnt + CW'(1);
  end

  always_comb begin
    score_inc = score_bcd;
    carry     = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (carry) begin
        if (score_bcd[4*i +: 4] == 4'd9) begin
          score_inc[4*i +: 4] = 4'd0;
        end else begin
          score_inc[4*i +: 4] = score_bcd[4*i +: 4] + 4'd1;
          carry               = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      score_bcd <= '0;
      overflow  <= 1'b0;
    end else if (clear) begin
      score_bcd <= '0;
      overflow  <= 1'b0;
    end else if (tick && run) begin
      score_bcd <= score_inc;
      if (carry) overflow <= 1'b1;
    end
  end

`ifdef SCORE_HISCORE_EN
  logic run_d;

  // Packed BCD orders the same as binary, so a plain magnitude compare works
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_d       <= 1'b0;
      hiscore_bcd <= '0;
    end else begin
      run_d <= run;
      if (run_d && !run && (score_bcd > hiscore_bcd)) hiscore_bcd <= score_bcd;
    end
  end

  assign disp = show_hi ? hiscore_bcd : score_bcd;
`else
  logic unused_show_hi;

  assign unused_show_hi = show_hi;
  assign hiscore_bcd    = '0;
  assign disp           = score_bcd;
`endif

  assign scan_wrap = (scan_cnt == SW'(SCAN_DIV - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scan_cnt <= '0;
      idx      <= '0;
    end else begin
      scan_cnt <= scan_wrap ? '0 : scan_cnt + SW'(1);
      idx      <= idx_nxt;
    end
  end

  always_comb begin
    idx_nxt = idx;
    if (scan_wrap) idx_nxt = (idx == IW'(DIGITS - 1)) ? '0 : idx + IW'(1);
  end

  // Walk from the top digit down so nz tells whether anything above is nonzero
  always_comb begin
    dig     = '0;
    blank   = 1'b0;
    sel_nxt = '0;
    nz      = 1'b0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      nz = nz | (disp[4*i +: 4] != 4'd0);
      if (IW'(i) == idx_nxt) begin
        dig        = disp[4*i +: 4];
        blank      = !nz && (i != 0);
        sel_nxt[i] = 1'b1;
      end
    end
  end

  function automatic logic [7:0] seg_enc(input logic [3:0] d);
    case (d)
      4'd0:    seg_enc = 8'b00000011;
      4'd1:    seg_enc = 8'b10011111;
      4'd2:    seg_enc = 8'b00100101;
      4'd3:    seg_enc = 8'b00001101;
      4'd4:    seg_enc = 8'b10011001;
      4'd5:    seg_enc = 8'b01001001;
      4'd6:    seg_enc = 8'b01000001;
      4'd7:    seg_enc = 8'b00011111;
      4'd8:    seg_enc = 8'b00000001;
      4'd9:    seg_enc = 8'b00001001;
      default: seg_enc = 8'b11111111;
    endcase
  endfunction

  // Select and segments come from the same next index so they never disagree
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_sel <= DIGITS'(1);
      SM      <= 8'b00000011;
    end else begin
      seg_sel <= sel_nxt;
      SM      <= blank ? 8'b11111111 : seg_enc(dig);
    end
  end

endmodule

// File: tb/tb_score_display_n.sv
// Directed bench for score_display_n (DIGITS=4, TICK_SLOW=10, TICK_FAST=5, SCAN_DIV=4).
// Exercises the high-score path too when SCORE_HISCORE_EN is defined.
module tb_score_display_n;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        run = 1'b0;
  logic        clear = 1'b0;
  logic        speed = 1'b0;
  logic        show_hi = 1'b0;
  logic [3:0]  seg_sel;
  logic [7:0]  SM;
  logic [15:0] score_bcd;
  logic [15:0] hiscore_bcd;
  logic        overflow;

  int vecs = 0;
  int errs = 0;

  score_display_n #(
    .DIGITS(4), .TICK_SLOW(10), .TICK_FAST(5), .SCAN_DIV(4)
  ) dut (
    .clk(clk), .rst_n(rst_n), .run(run), .clear(clear), .speed(speed),
    .show_hi(show_hi), .seg_sel(seg_sel), .SM(SM), .score_bcd(score_bcd),
    .hiscore_bcd(hiscore_bcd), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    vecs++;
    assert (got === want)
    else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, want);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Align to the start of digit 0 then check one full scan frame
  task automatic check_display(input string tag, input logic [7:0] e0, input logic [7:0] e1,
                               input logic [7:0] e2, input logic [7:0] e3);
    logic [7:0] sm_exp [4];
    logic [3:0] prev;
    bit         found;
    sm_exp = '{e0, e1, e2, e3};
    found  = 1'b0;
    prev   = seg_sel;
    for (int k = 0; k < 40 && !found; k++) begin
      step(1);
      if (prev == 4'b1000 && seg_sel == 4'b0001) found = 1'b1;
      prev = seg_sel;
    end
    chk({tag, "_sync"}, 32'(found), 32'd1);
    for (int k = 0; k < 16; k++) begin
      chk({tag, "_sel"}, 32'(seg_sel), 32'(1) << (k / 4));
      chk({tag, "_sm"}, 32'(SM), 32'(sm_exp[k / 4]));
      step(1);
    end
  endtask

  initial begin
    #1 rst_n = 1'b0;
    #1;
    chk("rst_score", 32'(score_bcd), 32'h0);
    chk("rst_hi", 32'(hiscore_bcd), 32'h0);
    chk("rst_ovf", 32'(overflow), 32'h0);
    chk("rst_sel", 32'(seg_sel), 32'h1);
    chk("rst_sm", 32'(SM), 32'b00000011);

    step(2);
    rst_n = 1'b1; run = 1'b1; speed = 1'b0;
    step(9);  chk("slow_9", 32'(score_bcd), 32'h0000);
    step(1);  chk("slow_10", 32'(score_bcd), 32'h0001);
    step(9);  chk("slow_19", 32'(score_bcd), 32'h0001);
    step(1);  chk("slow_20", 32'(score_bcd), 32'h0002);
    step(79); chk("slow_99", 32'(score_bcd), 32'h0009);
    step(1);  chk("slow_100", 32'(score_bcd), 32'h0010);

    step(7);  chk("spd_cnt7", 32'(score_bcd), 32'h0010);
    speed = 1'b1;
    step(1);  chk("spd_switch", 32'(score_bcd), 32'h0011);
    step(4);  chk("spd_fast4", 32'(score_bcd), 32'h0011);
    step(1);  chk("spd_fast5", 32'(score_bcd), 32'h0012);

    step(4);  chk("clr_pre", 32'(score_bcd), 32'h0012);
    clear = 1'b1;
    step(1);
    clear = 1'b0;
    chk("clr_tick", 32'(score_bcd), 32'h0000);
    step(4);  chk("clr_cnt4", 32'(score_bcd), 32'h0000);
    step(1);  chk("clr_cnt5", 32'(score_bcd), 32'h0001);

    run = 1'b0;
    step(22); chk("pause_hold", 32'(score_bcd), 32'h0001);
    run = 1'b1;
    step(2);  chk("pause_cnt", 32'(score_bcd), 32'h0001);
    step(1);  chk("pause_tick", 32'(score_bcd), 32'h0002);

    step(200);
    run = 1'b0;
    step(1);
    chk("run42", 32'(score_bcd), 32'h0042);
`ifdef SCORE_HISCORE_EN
    chk("hi42", 32'(hiscore_bcd), 32'h0042);
    show_hi = 1'b0;
`else
    chk("hi_off", 32'(hiscore_bcd), 32'h0);
    show_hi = 1'b1;
`endif
    check_display("disp42", 8'b00100101, 8'b10011001, 8'b11111111, 8'b11111111);
    show_hi = 1'b0;

`ifdef SCORE_HISCORE_EN
    rst_n = 1'b0;
    #1 chk("hi_rst", 32'(hiscore_bcd), 32'h0);
    step(1);
    rst_n = 1'b1; run = 1'b1; speed = 1'b1;
    step(175); chk("game1", 32'(score_bcd), 32'h0035);
    run = 1'b0;
    step(1);   chk("hi_load", 32'(hiscore_bcd), 32'h0035);
    clear = 1'b1;
    step(1);
    clear = 1'b0;
    chk("hi_clr_score", 32'(score_bcd), 32'h0);
    chk("hi_clr_keep", 32'(hiscore_bcd), 32'h0035);
    run = 1'b1;
    step(98);  chk("game2", 32'(score_bcd), 32'h0020);
    run = 1'b0;
    step(1);   chk("hi_keep", 32'(hiscore_bcd), 32'h0035);
    show_hi = 1'b1;
    check_display("hi35", 8'b01001001, 8'b00001101, 8'b11111111, 8'b11111111);
    show_hi = 1'b0;
`endif

    run = 1'b1; speed = 1'b1;
    step(3);
    rst_n = 1'b0;
    #1;
    chk("arst_score", 32'(score_bcd), 32'h0);
    chk("arst_sel", 32'(seg_sel), 32'h1);
    chk("arst_sm", 32'(SM), 32'b00000011);
    step(1);
    rst_n = 1'b1;
    step(4);     chk("arst_cnt4", 32'(score_bcd), 32'h0000);
    step(1);     chk("arst_cnt5", 32'(score_bcd), 32'h0001);
    step(49990); chk("ovf_9999", 32'(score_bcd), 32'h9999);
    chk("ovf_pre", 32'(overflow), 32'h0);
    step(4);     chk("ovf_hold", 32'(score_bcd), 32'h9999);
    step(1);     chk("ovf_wrap", 32'(score_bcd), 32'h0000);
    chk("ovf_set", 32'(overflow), 32'h1);
    step(5);     chk("ovf_after", 32'(score_bcd), 32'h0001);
    chk("ovf_sticky", 32'(overflow), 32'h1);
    clear = 1'b1;
    step(1);
    clear = 1'b0;
    chk("ovf_clr_score", 32'(score_bcd), 32'h0);
    chk("ovf_clr", 32'(overflow), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
